// File: rtl/wb_timer_pkg.sv
// Shared register map and channel-control bit positions for the multi-channel Wishbone timer.
package wb_timer_pkg;

    localparam int REG_CTRL   = 0;
    localparam int REG_PRESC  = 1;
    localparam int REG_COUNT  = 2;
    localparam int REG_STATUS = 3;
    localparam int CH_BASE    = 4;
    localparam int CH_STRIDE  = 4;
    localparam int CH_CMP     = 0;
    localparam int CH_PERIOD  = 1;
    localparam int CH_CTRL    = 2;

    localparam int CHCTRL_EN       = 0;
    localparam int CHCTRL_PERIODIC = 1;
    localparam int CHCTRL_IE       = 2;
    localparam int CHCTRL_W        = 3;

    function automatic int ch_reg(input int k, input int r);
        return CH_BASE + CH_STRIDE * k + r;
    endfunction

endpackage

// File: rtl/wb_timer_chan.sv
// One compare channel: CMP/PERIOD/CHCTRL registers, match and reload logic, pending and irq flops.
module wb_timer_chan
    import wb_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CNT_W-1:0]    count,
    input  logic                upd,
    input  logic [CNT_W-1:0]    wdata,
    input  logic                wr_cmp,
    input  logic                wr_period,
    input  logic                wr_ctrl,
    input  logic                clr,
    output logic [CNT_W-1:0]    cmp,
    output logic [CNT_W-1:0]    period,
    output logic [CHCTRL_W-1:0] ctrl,
    output logic                pending,
    output logic                irq
);

    logic match;

    // upd only follows a tick, so a held or bus-loaded counter never matches
    assign match = upd & ctrl[CHCTRL_EN] & (count == cmp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp     <= '0;
            period  <= '0;
            ctrl    <= '0;
            pending <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_cmp)
                cmp <= wdata;
            else if (match && ctrl[CHCTRL_PERIODIC])
                cmp <= cmp + period;

            if (wr_period)
                period <= wdata;

            if (wr_ctrl)
                ctrl <= wdata[CHCTRL_W-1:0];
            else if (match && !ctrl[CHCTRL_PERIODIC])
                ctrl[CHCTRL_EN] <= 1'b0;

            if (match)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;

            irq <= pending & ctrl[CHCTRL_IE];
        end
    end

endmodule

// File: rtl/wb_timer_multi.sv
// Multi-channel Wishbone timer: bus decode, shared prescaler and free-running counter,
// and N_CH compare channels whose enabled pending bits form the interrupt outputs.
module wb_timer_multi
    import wb_timer_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16,
    parameter int AW      = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   wb_addr,
    input  logic [31:0]     wb_wdata,
    output logic [31:0]     wb_rdata,
    input  logic            wb_we,
    input  logic            wb_cyc,
    output logic            wb_ack,
    output logic [N_CH-1:0] irq,
    output logic            irq_any
);

    logic                en;
    logic [PRESC_W-1:0]  presc;
    logic [PRESC_W-1:0]  pcnt;
    logic [CNT_W-1:0]    count;
    logic                upd;
    logic                tick;
    logic                acc;
    logic                wr;
    logic                count_wr;
    logic [31:0]         rd_val;
    logic [N_CH-1:0]     pending;
    logic [CNT_W-1:0]    cmp_q    [N_CH];
    logic [CNT_W-1:0]    period_q [N_CH];
    logic [CHCTRL_W-1:0] ctrl_q   [N_CH];
    logic                unused_wdata;

    assign unused_wdata = ^wb_wdata;

    assign acc      = wb_cyc & ~wb_ack;
    assign wr       = acc & wb_we;
    assign count_wr = wr && (wb_addr == AW'(REG_COUNT));
    assign tick     = en && (pcnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_rdata <= '0;
        end else begin
            wb_ack   <= acc;
            wb_rdata <= acc ? rd_val : '0;
        end
    end

    // a COUNT write beats a same-cycle tick and restarts the prescaler phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en    <= 1'b0;
            presc <= '0;
            pcnt  <= '0;
            count <= '0;
            upd   <= 1'b0;
        end else begin
            if (wr && (wb_addr == AW'(REG_CTRL)))
                en <= wb_wdata[0];
            if (wr && (wb_addr == AW'(REG_PRESC)))
                presc <= wb_wdata[PRESC_W-1:0];

            if (count_wr) begin
                count <= wb_wdata[CNT_W-1:0];
                pcnt  <= presc;
            end else begin
                if (en)
                    pcnt <= (pcnt == '0) ? presc : pcnt - 1'b1;
                if (tick)
                    count <= count + 1'b1;
            end

            upd <= tick & ~count_wr;
        end
    end

    always_comb begin
        rd_val = '0;
        if (wb_addr == AW'(REG_CTRL))
            rd_val[0] = en;
        if (wb_addr == AW'(REG_PRESC))
            rd_val[PRESC_W-1:0] = presc;
        if (wb_addr == AW'(REG_COUNT))
            rd_val[CNT_W-1:0] = count;
        if (wb_addr == AW'(REG_STATUS))
            rd_val[N_CH-1:0] = pending;
        for (int k = 0; k < N_CH; k++) begin
            if (wb_addr == AW'(ch_reg(k, CH_CMP)))
                rd_val[CNT_W-1:0] = cmp_q[k];
            if (wb_addr == AW'(ch_reg(k, CH_PERIOD)))
                rd_val[CNT_W-1:0] = period_q[k];
            if (wb_addr == AW'(ch_reg(k, CH_CTRL)))
                rd_val[CHCTRL_W-1:0] = ctrl_q[k];
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        wb_timer_chan #(.CNT_W(CNT_W)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .count     (count),
            .upd       (upd),
            .wdata     (wb_wdata[CNT_W-1:0]),
            .wr_cmp    (wr && (wb_addr == AW'(ch_reg(g, CH_CMP)))),
            .wr_period (wr && (wb_addr == AW'(ch_reg(g, CH_PERIOD)))),
            .wr_ctrl   (wr && (wb_addr == AW'(ch_reg(g, CH_CTRL)))),
            .clr       (wr && (wb_addr == AW'(REG_STATUS)) && wb_wdata[g]),
            .cmp       (cmp_q[g]),
            .period    (period_q[g]),
            .ctrl      (ctrl_q[g]),
            .pending   (pending[g]),
            .irq       (irq[g])
        );
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_wb_timer_multi.sv
// Bench for wb_timer_multi: a 32-bit and an 8-bit counter instance on a shared bus,
// checked against tick-arithmetic expectations derived from the register rules.
module tb_wb_timer_multi;

    localparam logic [4:0] A_CTRL = 5'd0, A_PRESC = 5'd1, A_COUNT = 5'd2, A_STATUS = 5'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc_a = 1'b0, cyc_b = 1'b0, wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, ack_b, any_a, any_b;
    logic [3:0]  irq_a, irq_b;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int last_edge = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    wb_timer_multi #(.N_CH(4), .CNT_W(32), .PRESC_W(16), .AW(5)) dut (
        .clk(clk), .rst(rst), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(rdata_a),
        .wb_we(wb_we), .wb_cyc(cyc_a), .wb_ack(ack_a), .irq(irq_a), .irq_any(any_a));

    wb_timer_multi #(.N_CH(4), .CNT_W(8), .PRESC_W(16), .AW(5)) dut8 (
        .clk(clk), .rst(rst), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(rdata_b),
        .wb_we(wb_we), .wb_cyc(cyc_b), .wb_ack(ack_b), .irq(irq_b), .irq_any(any_b));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ch_addr(input int k, input int r);
        return 5'(4 + 4 * k + r);
    endfunction

    // one access: ack must be high exactly in the cycle after cyc, then drop with rdata back to 0
    task automatic bus(input bit sel, input bit we_i, input logic [4:0] a, input logic [31:0] d,
                       output logic [31:0] q);
        wb_addr = a; wb_wdata = d; wb_we = we_i;
        if (sel) cyc_b = 1'b1; else cyc_a = 1'b1;
        @(posedge clk); #1;
        last_edge = cyc_n;
        q = sel ? rdata_b : rdata_a;
        check_val("ack_pulse", {31'b0, sel ? ack_b : ack_a}, 32'd1);
        cyc_a = 1'b0; cyc_b = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        check_val("ack_drop", {31'b0, sel ? ack_b : ack_a}, 32'd0);
        check_val("rdata_idle", sel ? rdata_b : rdata_a, 32'd0);
    endtask

    task automatic wr(input bit sel, input logic [4:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus(sel, 1'b1, a, d, q);
    endtask

    task automatic rd_chk(input bit sel, input logic [4:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] q;
        bus(sel, 1'b0, a, 32'd0, q);
        check_val(tag, q, exp);
    endtask

    task automatic rd(input bit sel, input logic [4:0] a, output logic [31:0] q);
        bus(sel, 1'b0, a, 32'd0, q);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(input int t);
        for (int i = 0; i < 1000 && cyc_n < t; i++) begin @(posedge clk); #1; end
        check_val("sync_edge", cyc_n, t);
    endtask

    task automatic wait_irq(input bit sel, input int k, output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            if ((sel ? irq_b[k] : irq_a[k]) === 1'b1) begin
                at = cyc_n;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q, c0;
        int P, p, d, n, w, w0, at, t_hit;
        int addrs[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 31};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // reset state
        check_val("rst_ack", {31'b0, ack_a}, 0);
        check_val("rst_irq_any", {31'b0, any_a}, 0);
        check_val("rst_irq", {28'b0, irq_a}, 0);
        foreach (addrs[i]) rd_chk(0, 5'(addrs[i]), 0, "rst_reg");

        // plain read/write, unused high bits, unmapped address
        wr(0, A_PRESC, 32'h1234);
        rd_chk(0, A_PRESC, 32'h1234, "presc_rb");
        wr(0, ch_addr(0, 2), 32'hFFFF_FFFF);
        rd_chk(0, ch_addr(0, 2), 32'h7, "chctrl_hi_bits");
        wr(0, ch_addr(0, 2), 32'h0);
        wr(0, 5'd31, 32'hFFFF_FFFF);
        rd_chk(0, 5'd31, 0, "unmapped_rd");

        // free-running counter with random prescale, then frozen by EN=0
        for (int it = 0; it < 6; it++) begin
            P  = (it == 0) ? 3 : $urandom_range(0, 3);
            c0 = (it == 0) ? 32'd0 : (it == 1) ? 32'hFFFF_FFF8 : $urandom;
            n  = (it == 0) ? 18 : $urandom_range(0, 30);
            wr(0, A_CTRL, 0);
            wr(0, A_PRESC, P);
            wr(0, A_COUNT, c0);
            wr(0, A_CTRL, 1);
            w = last_edge;
            idle(n);
            rd(0, A_COUNT, q);
            check_val("count_run", q, c0 + 32'((last_edge - 1 - w) / (P + 1)));
            wr(0, A_CTRL, 0);
            w0 = last_edge;
            idle($urandom_range(1, 12));
            rd_chk(0, A_COUNT, c0 + 32'((w0 - w) / (P + 1)), "count_frozen");
        end

        // COUNT write landing on a tick edge: written value, no increment
        wr(0, A_PRESC, 0);
        wr(0, A_COUNT, 0);
        wr(0, A_CTRL, 1);
        wr(0, A_COUNT, 32'h100);
        w = last_edge;
        rd(0, A_COUNT, q);
        check_val("count_wr_tick", q, 32'h100 + 32'(last_edge - 1 - w));

        // one-shot on channel 0
        for (int it = 0; it < 3; it++) begin
            P  = (it == 0) ? 0 : $urandom_range(0, 3);
            d  = (it == 0) ? 10 : $urandom_range(1, 20);
            c0 = (it == 0) ? 32'd0 : $urandom;
            wr(0, A_CTRL, 0);
            wr(0, ch_addr(0, 0), c0 + 32'(d));
            wr(0, ch_addr(0, 2), 32'h5);
            wr(0, A_PRESC, P);
            wr(0, A_COUNT, c0);
            wr(0, A_CTRL, 1);
            w = last_edge;
            wait_irq(0, 0, at);
            check_val("oneshot_irq_time", at, w + d * (P + 1) + 2);
            check_val("oneshot_irq_any", {31'b0, any_a}, 1);
            rd_chk(0, ch_addr(0, 2), 32'h4, "oneshot_chctrl");
            rd_chk(0, A_STATUS, 32'h1, "oneshot_status");
            wr(0, A_STATUS, 32'h1);
            check_val("oneshot_clr", {28'b0, irq_a}, 0);
        end

        // periodic on channel 1: three hits, cleared between
        P  = $urandom_range(1, 3);
        p  = $urandom_range(4, 8);
        d  = $urandom_range(1, 10);
        c0 = $urandom;
        wr(0, A_CTRL, 0);
        wr(0, ch_addr(1, 0), c0 + 32'(d));
        wr(0, ch_addr(1, 1), p);
        wr(0, ch_addr(1, 2), 32'h7);
        wr(0, A_PRESC, P);
        wr(0, A_COUNT, c0);
        wr(0, A_CTRL, 1);
        w = last_edge;
        for (int h = 0; h < 3; h++) begin
            t_hit = w + (d + h * p) * (P + 1);
            wait_irq(0, 1, at);
            check_val("periodic_irq_time", at, t_hit + 2);
            rd_chk(0, A_STATUS, 32'h2, "periodic_status");
            wr(0, A_STATUS, 32'h2);
            check_val("periodic_clr", {31'b0, irq_a[1]}, 0);
        end
        rd_chk(0, ch_addr(1, 0), c0 + 32'(d + 3 * p), "periodic_cmp");
        wr(0, ch_addr(1, 2), 0);
        wr(0, A_CTRL, 0);
        wr(0, A_STATUS, 32'hF);

        // W1C on the match edge of channel 3: set wins
        wr(0, ch_addr(3, 0), 32'h44);
        wr(0, ch_addr(3, 2), 32'h5);
        wr(0, A_PRESC, 1);
        wr(0, A_COUNT, 32'h40);
        wr(0, A_CTRL, 1);
        w = last_edge;
        wait_until(w + 8);
        wr(0, A_STATUS, 32'h8);
        check_val("collide_irq3", {31'b0, irq_a[3]}, 1);
        rd_chk(0, A_STATUS, 32'h8, "collide_status");

        // 8-bit counter wrap, one-shot and periodic reload
        wr(1, A_CTRL, 0);
        wr(1, ch_addr(2, 0), 32'h01);
        wr(1, ch_addr(2, 2), 32'h5);
        wr(1, A_PRESC, 0);
        wr(1, A_COUNT, 32'hFE);
        wr(1, A_CTRL, 1);
        w = last_edge;
        wait_irq(1, 2, at);
        check_val("wrap_irq_time", at, w + 3 + 2);
        wr(1, A_CTRL, 0);
        wr(1, ch_addr(1, 0), 32'hFC);
        wr(1, ch_addr(1, 1), 32'h08);
        wr(1, ch_addr(1, 2), 32'h3);
        wr(1, A_COUNT, 32'hFA);
        wr(1, A_CTRL, 1);
        idle(3);
        wr(1, A_CTRL, 0);
        rd_chk(1, ch_addr(1, 0), 32'h04, "wrap_periodic_cmp");
        rd_chk(1, A_STATUS, 32'h6, "wrap_status");

        // reset while ack is high, then reset before a write's ack edge
        check_val("pre_rst_irq_any", {31'b0, any_a}, 1);
        wb_addr = A_COUNT; wb_we = 1'b0; cyc_a = 1'b1;
        @(posedge clk); #1;
        check_val("mid_ack", {31'b0, ack_a}, 1);
        rst = 1'b1;
        #1;
        check_val("rst_async_ack", {31'b0, ack_a}, 0);
        check_val("rst_async_irq_any", {31'b0, any_a}, 0);
        check_val("rst_async_rdata", rdata_a, 0);
        cyc_a = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        wb_addr = A_PRESC; wb_wdata = 32'h55; wb_we = 1'b1; cyc_a = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_hold_ack", {31'b0, ack_a}, 0);
        cyc_a = 1'b0; wb_we = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rd_chk(0, A_PRESC, 0, "lost_write");
        rd_chk(0, A_CTRL, 0, "post_rst_ctrl");
        rd_chk(0, A_COUNT, 0, "post_rst_count");
        rd_chk(0, A_STATUS, 0, "post_rst_status");
        rd_chk(0, ch_addr(3, 0), 0, "post_rst_cmp3");
        rd_chk(0, ch_addr(3, 2), 0, "post_rst_chctrl3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
